instruction_fetch_unit: RTL

Fetch stage of the X-Makina multi-cycle CPU. It sits directly upstream of instruction_decoder_unit_m and owns the program counter (PC). On request from the control unit it runs a word read from instruction memory and latches the result into the instruction register. The instruction register drives the decoder's inst_data input, and the PC is advanced by 2 or overwritten by a branch/PC write.

---
 rtl/instruction_fetch_if.sv | 28 ++
 rtl/instruction_fetch_unit.sv | 103 ++++++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// Bus between the control unit / instruction memory and the fetch stage.
// The slave modport is the fetch unit. The master modport is the side that
// issues fetch and PC-write requests, answers memory reads and consumes the
// fetched instruction.
interface instruction_fetch_if;
  logic        fetch_start;
  logic        pc_wr;
  logic [15:0] pc_wr_data;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic [15:0] inst_data;
  logic [15:0] inst_addr;
  logic        inst_valid;
  logic [15:0] pc;
  logic        busy;

  modport slave (
    input  fetch_start, pc_wr, pc_wr_data, mem_ready, mem_rdata,
    output mem_rd, mem_addr, inst_data, inst_addr, inst_valid, pc, busy
  );

  modport master (
    output fetch_start, pc_wr, pc_wr_data, mem_ready, mem_rdata,
    input  mem_rd, mem_addr, inst_data, inst_addr, inst_valid, pc, busy
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the X-Makina multi-cycle CPU. It owns the program counter,
// runs one word read per fetch request, and latches the returned word into
// the instruction register that feeds the decoder.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          PC_STEP  = 2
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] RESET_PC_ALIGNED = RESET_PC & 16'hFFFE;
  localparam logic [15:0] STEP             = 16'(PC_STEP);

  state_t      state;
  logic [15:0] pc_q;
  logic [15:0] inst_data_q;
  logic [15:0] inst_addr_q;
  logic [15:0] pend_pc;
  logic        pend_valid;
  logic [15:0] wr_pc;
  logic [15:0] next_pc;

  assign wr_pc = bus.pc_wr_data & 16'hFFFE;

  // PC to load when the outstanding read completes: a write in the completing
  // cycle beats an earlier pending write, which beats the plain increment.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    next_pc = (pc_q + STEP) & 16'hFFFE;
    if (bus.pc_wr) begin
      next_pc = wr_pc;
    end else if (pend_valid) begin
      next_pc = pend_pc;
    end
  end

  // Fetch sequencer, PC, pending PC write and instruction register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    if (!reset) begin
      state       <= IDLE;
      pc_q        <= RESET_PC_ALIGNED;
      inst_data_q <= 16'h0000;
      inst_addr_q <= 16'h0000;
      pend_pc     <= 16'h0000;
      pend_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A write alongside fetch_start lands first, so the read sees it.
          if (bus.pc_wr) begin
            pc_q <= wr_pc;
          end
          if (bus.fetch_start) begin
            state <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_ready) begin
            inst_data_q <= bus.mem_rdata;
            inst_addr_q <= pc_q;
            pc_q        <= next_pc;
            pend_valid  <= 1'b0;
            state       <= DONE;
          end else if (bus.pc_wr) begin
            // Keep the address stable mid-read; apply the write on completion.
            pend_pc    <= wr_pc;
            pend_valid <= 1'b1;
          end
        end
        DONE: begin
          if (bus.pc_wr) begin
            pc_q <= wr_pc;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory request and status decode straight from the registered state.
  assign bus.mem_rd     = (state == REQ);
  assign bus.mem_addr   = pc_q;
  assign bus.inst_valid = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.pc         = pc_q;
  assign bus.inst_data  = inst_data_q;
  assign bus.inst_addr  = inst_addr_q;

endmodule
